adder_operand_seq: RTL and testbench

Upstream/downstream sequencer for the Basys3 4-bit full adder (fulladd4). It captures operands A, B and carry-in from the board switches on successive debounced button presses and drives them onto the adder inputs. It then registers the adder's SUM/C_OUT into a held 5-bit result for display. This makes the combinational adder usable on the board, one press at a time.

---
 rtl/adder_operand_seq.sv | 108 ++++++++++
 tb/tb_adder_operand_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_operand_seq.sv
// Sequencer around the board 4-bit adder: debounced presses load A, then B/cin, then the registered sum.
// A clean press reaches the operand registers DEBOUNCE_CYCLES+3 edges after the button edge; there is no backpressure.
module adder_operand_seq #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic [3:0] sw_data,
  input  logic       sw_cin,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic       cin_out,
  input  logic [3:0] sum_in,
  input  logic       cout_in,
  output logic [4:0] result,
  output logic       result_valid,
  output logic [1:0] state_led
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] LOAD_A = 2'b00;
  localparam logic [1:0] LOAD_B = 2'b01;
  localparam logic [1:0] SETTLE = 2'b10;
  localparam logic [1:0] SHOW   = 2'b11;

  logic             sync_q1;
  logic             sync_q2;
  logic             db;
  logic [CNT_W-1:0] cnt;
  logic             press;
  logic [1:0]       state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_next;
      sync_q2 <= sync_q1;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive clocks away from db;
  // only the accepted rising level yields the one-cycle press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db    <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_q2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db    <= sync_q2;
        cnt   <= '0;
        press <= sync_q2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD_A;
      a_out        <= 4'd0;
      b_out        <= 4'd0;
      cin_out      <= 1'b0;
      result       <= 5'd0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (press) begin
            a_out <= sw_data;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (press) begin
            b_out   <= sw_data;
            cin_out <= sw_cin;
            state   <= SETTLE;
          end
        end
        // The adder has had the full previous cycle to settle on the new operands.
        SETTLE: begin
          result       <= {cout_in, sum_in};
          result_valid <= 1'b1;
          state        <= SHOW;
        end
        default: begin
          if (press) begin
            result_valid <= 1'b0;
            state        <= LOAD_A;
          end
        end
      endcase
    end
  end

  assign state_led = state;

endmodule

// File: tb/tb_adder_operand_seq.sv
// Randomized bench for adder_operand_seq with a behavioural adder on its operand outputs.
module tb_adder_operand_seq;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_next;
  logic [3:0] sw_data;
  logic       sw_cin;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic       cin_out;
  logic [3:0] sum_in;
  logic       cout_in;
  logic [4:0] result;
  logic       result_valid;
  logic [1:0] state_led;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] exp_q[$];
  logic [4:0] last_exp = 5'd0;
  logic [3:0] model_a  = 4'd0;
  logic [3:0] model_b  = 4'd0;
  logic       model_c  = 1'b0;

  always #5 clk = ~clk;

  // Stand-in for fulladd4.
  logic [4:0] add_full;
  assign add_full = {1'b0, a_out} + {1'b0, b_out} + {4'd0, cin_out};
  assign sum_in   = add_full[3:0];
  assign cout_in  = add_full[4];

  adder_operand_seq #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_next     (btn_next),
    .sw_data      (sw_data),
    .sw_cin       (sw_cin),
    .a_out        (a_out),
    .b_out        (b_out),
    .cin_out      (cin_out),
    .sum_in       (sum_in),
    .cout_in      (cout_in),
    .result       (result),
    .result_valid (result_valid),
    .state_led    (state_led)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: each new completed addition must match the oldest outstanding expectation.
  logic prev_vld = 1'b0;
  always @(negedge clk) begin
    logic [4:0] e;
    if (result_valid === 1'b1 && prev_vld === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL result_unexpected: got %0d, expected no result", result);
      end else begin
        e = exp_q.pop_front();
        check("result", {27'd0, result}, {27'd0, e});
      end
    end
    prev_vld = result_valid;
  end

  // Raise the button and return at the negedge after the edge that applies the press.
  task automatic press_hold(input logic [3:0] d, input logic c);
    @(negedge clk);
    sw_data  = d;
    sw_cin   = c;
    btn_next = 1'b1;
    repeat (DB + 3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_btn();
    btn_next = 1'b0;
    sw_data  = 4'($urandom);
    sw_cin   = 1'($urandom);
    repeat (DB + 6) @(negedge clk);
  endtask

  task automatic do_a(input logic [3:0] a);
    press_hold(a, 1'($urandom));
    model_a = a;
    check("a_load", {28'd0, a_out}, {28'd0, model_a});
    check("state_load_b", {30'd0, state_led}, 32'd1);
    release_btn();
  endtask

  task automatic do_b(input logic [3:0] b, input logic c);
    press_hold(b, c);
    model_b  = b;
    model_c  = c;
    last_exp = 5'({1'b0, model_a} + {1'b0, model_b} + {4'd0, model_c});
    exp_q.push_back(last_exp);
    check("b_load", {28'd0, b_out}, {28'd0, model_b});
    check("cin_load", {31'd0, cin_out}, {31'd0, model_c});
    check("state_settle", {30'd0, state_led}, 32'd2);
    check("valid_in_settle", {31'd0, result_valid}, 32'd0);
    @(negedge clk);
    check("state_show", {30'd0, state_led}, 32'd3);
    check("valid_in_show", {31'd0, result_valid}, 32'd1);
    release_btn();
  endtask

  task automatic do_wrap();
    press_hold(4'($urandom), 1'($urandom));
    check("wrap_state", {30'd0, state_led}, 32'd0);
    check("wrap_valid", {31'd0, result_valid}, 32'd0);
    check("wrap_result_held", {27'd0, result}, {27'd0, last_exp});
    check("wrap_a_held", {28'd0, a_out}, {28'd0, model_a});
    release_btn();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a"}, {28'd0, a_out}, 32'd0);
    check({tag, "_b"}, {28'd0, b_out}, 32'd0);
    check({tag, "_cin"}, {31'd0, cin_out}, 32'd0);
    check({tag, "_result"}, {27'd0, result}, 32'd0);
    check({tag, "_valid"}, {31'd0, result_valid}, 32'd0);
    check({tag, "_state"}, {30'd0, state_led}, 32'd0);
  endtask

  task automatic reset_mid_cycle(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    model_a  = 4'd0;
    model_b  = 4'd0;
    model_c  = 1'b0;
    last_exp = 5'd0;
    exp_q.delete();
    btn_next = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    btn_next = 1'b0;
    sw_data  = 4'd0;
    sw_cin   = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic add and wrap.
    do_a(4'd3);
    do_b(4'd4, 1'b0);
    check("basic_const", {27'd0, last_exp}, 32'b00111);
    do_wrap();

    // Carry out cases.
    do_a(4'd9);
    do_b(4'd9, 1'b0);
    do_wrap();
    do_a(4'd10);
    do_b(4'd15, 1'b1);
    reset_mid_cycle("rst_show");

    // Short glitch must not register.
    @(negedge clk);
    btn_next = 1'b1;
    repeat (2) @(negedge clk);
    btn_next = 1'b0;
    repeat (DB + 6) @(negedge clk);
    check("glitch_state", {30'd0, state_led}, 32'd0);
    check("glitch_a", {28'd0, a_out}, 32'd0);

    // 50-cycle hold: one press, applied at edge DB+3.
    sw_data  = 4'd6;
    btn_next = 1'b1;
    repeat (DB + 2) @(posedge clk);
    @(negedge clk);
    check("hold_before_press", {30'd0, state_led}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("hold_after_press", {30'd0, state_led}, 32'd1);
    check("hold_a", {28'd0, a_out}, 32'd6);
    model_a = 4'd6;
    repeat (50 - (DB + 3)) @(negedge clk);
    release_btn();
    check("hold_single_press", {30'd0, state_led}, 32'd1);
    do_b(4'd5, 1'b1);
    do_wrap();

    // Random operands.
    for (int i = 0; i < 12; i++) begin
      do_a(4'($urandom));
      do_b(4'($urandom), 1'($urandom));
      do_wrap();
    end

    // Reset while waiting for B.
    do_a(4'd7);
    reset_mid_cycle("rst_load_b");
    do_a(4'd2);
    do_b(4'd5, 1'b0);
    check("post_reset_const", {27'd0, last_exp}, 32'b00111);
    repeat (3) @(negedge clk);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
